// File: rtl/ov7670_sccb_config_if.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_sccb_config_if
// Brief    : Table-ROM and SCCB pin bundle between the config master and the
//            camera top level (which owns the ROM and the SIO_D tristate).
// Revision : 1.0 - initial release
// ============================================================================
interface ov7670_sccb_config_if;
    logic [7:0]  RomAddr;
    logic [15:0] RomData;
    logic        SIO_C;
    logic        SIO_D_OUT;
    logic        SIO_D_OE;

    modport master (
        output RomAddr,
        input  RomData,
        output SIO_C,
        output SIO_D_OUT,
        output SIO_D_OE
    );

    modport slave (
        input  RomAddr,
        output RomData,
        input  SIO_C,
        input  SIO_D_OUT,
        input  SIO_D_OE
    );
endinterface
`default_nettype wire

// File: rtl/ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_sccb_config
// Brief    : SCCB write master that walks a {register,value} table after reset
//            and programs the OV7670, honouring delay and end markers.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_sccb_config #(
    parameter int         QUARTER      = 125,
    parameter int         DELAY_CYCLES = 50000,
    parameter logic [7:0] DEV_ID       = 8'h42
) (
    input  wire logic                  Clock,
    input  wire logic                  NotReset,
    input  wire logic                  Start,
    ov7670_sccb_config_if.master       bus,
    output logic                       Busy,
    output logic                       Done,
    output logic [7:0]                 WriteCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_BITS  = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5,
        S_DELAY = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam int              c_QW       = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int              c_DW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [c_QW-1:0] c_Q_LAST   = c_QW'(QUARTER - 1);
    localparam logic [c_DW-1:0] c_D_LAST   = c_DW'(DELAY_CYCLES - 1);
    localparam logic [4:0]      c_LAST_BIT = 5'd26;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_QW-1:0] r_qcnt;
    logic [1:0]      r_qidx;
    logic [4:0]      r_bit;
    logic [26:0]     r_shift;
    logic [c_DW-1:0] r_dcnt;
    logic [7:0]      r_addr;
    logic [7:0]      r_wcount;
    logic            r_busy;

    logic w_qtick;
    logic w_phase_end;
    logic w_in_frame;
    logic w_dc_bit;
    logic w_gap_end;
    logic w_delay_end;
    logic w_restart;
    logic w_sio_c;
    logic w_sio_d;
    logic w_sio_oe;

    assign w_qtick     = (r_qcnt == c_Q_LAST);
    assign w_phase_end = w_qtick && (r_qidx == 2'd3);
    assign w_in_frame  = (r_state == S_START) || (r_state == S_BITS) ||
                         (r_state == S_STOP)  || (r_state == S_GAP);
    // Ninth bit of each byte phase is the released don't-care slot.
    assign w_dc_bit    = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);
    assign w_gap_end   = (r_state == S_GAP) && w_phase_end;
    assign w_delay_end = (r_state == S_DELAY) && (r_dcnt == c_D_LAST);
    assign w_restart   = ((r_state == S_IDLE) || (r_state == S_DONE)) && Start;

    always_ff @(posedge Clock or negedge NotReset) begin
        if (!NotReset) begin
            r_state  <= S_FETCH;
            r_qcnt   <= '0;
            r_qidx   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_dcnt   <= '0;
            r_addr   <= '0;
            r_wcount <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);

            if (w_in_frame) begin
                if (w_qtick) begin
                    r_qcnt <= '0;
                    r_qidx <= r_qidx + 2'd1;
                end else begin
                    r_qcnt <= r_qcnt + 1'b1;
                end
            end else begin
                r_qcnt <= '0;
                r_qidx <= '0;
            end

            if (r_state == S_FETCH) begin
                r_bit   <= '0;
                r_shift <= {DEV_ID, 1'b1, bus.RomData[15:8], 1'b1, bus.RomData[7:0], 1'b1};
            end else if ((r_state == S_BITS) && w_phase_end) begin
                r_bit   <= r_bit + 5'd1;
                r_shift <= {r_shift[25:0], 1'b1};
            end

            r_dcnt <= (r_state == S_DELAY) ? r_dcnt + 1'b1 : '0;

            if (w_restart) begin
                r_addr   <= '0;
                r_wcount <= '0;
            end else begin
                if (w_delay_end || (w_gap_end && (r_addr != 8'hFF)))
                    r_addr <= r_addr + 8'd1;
                if (w_gap_end && (r_wcount != 8'hFF))
                    r_wcount <= r_wcount + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sio_c      = 1'b1;
        w_sio_d      = 1'b1;
        w_sio_oe     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Start)
                    w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.RomData == 16'hFFFF)
                    w_state_next = S_DONE;
                else if (bus.RomData == 16'hFFF0)
                    w_state_next = S_DELAY;
                else
                    w_state_next = S_START;
            end
            S_START: begin
                w_sio_oe = 1'b1;
                w_sio_c  = (r_qidx != 2'd3);
                w_sio_d  = (r_qidx == 2'd0);
                if (w_phase_end)
                    w_state_next = S_BITS;
            end
            S_BITS: begin
                // Clock low for q0/q1, high for q2/q3; data moves only at q0.
                w_sio_c  = r_qidx[1];
                w_sio_d  = r_shift[26];
                w_sio_oe = !w_dc_bit;
                if (w_phase_end && (r_bit == c_LAST_BIT))
                    w_state_next = S_STOP;
            end
            S_STOP: begin
                w_sio_oe = 1'b1;
                w_sio_c  = (r_qidx != 2'd0);
                w_sio_d  = r_qidx[1];
                if (w_phase_end)
                    w_state_next = S_GAP;
            end
            S_GAP: begin
                if (w_phase_end)
                    w_state_next = (r_addr == 8'hFF) ? S_DONE : S_FETCH;
            end
            S_DELAY: begin
                if (w_delay_end)
                    w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    assign bus.RomAddr   = r_addr;
    assign bus.SIO_C     = w_sio_c;
    assign bus.SIO_D_OUT = w_sio_d;
    assign bus.SIO_D_OE  = w_sio_oe;
    assign Busy          = r_busy;
    assign Done          = (r_state == S_DONE);
    assign WriteCount    = r_wcount;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_sccb_config
// Brief    : Directed self-checking bench for the SCCB table walker; decodes
//            frames from the SIO pins and compares them to hand-built values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ov7670_sccb_config;

    localparam int Q   = 2;
    localparam int DLY = 10;

    logic       Clock    = 1'b0;
    logic       NotReset = 1'b0;
    logic       Start    = 1'b0;
    logic       Busy;
    logic       Done;
    logic [7:0] WriteCount;

    ov7670_sccb_config_if bus();

    logic [15:0] rom [256];
    assign bus.RomData = rom[bus.RomAddr];

    ov7670_sccb_config #(
        .QUARTER      (Q),
        .DELAY_CYCLES (DLY),
        .DEV_ID       (8'h42)
    ) dut (
        .Clock      (Clock),
        .NotReset   (NotReset),
        .Start      (Start),
        .bus        (bus),
        .Busy       (Busy),
        .Done       (Done),
        .WriteCount (WriteCount)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Pin-level frame decoder: start/stop are data edges while SIO_C is high,
    // bits are sampled at SIO_C rising edges (released data reads as 1).
    logic        prev_c   = 1'b1;
    logic        prev_d   = 1'b1;
    logic        in_frame = 1'b0;
    logic [31:0] cur_bits;
    logic [31:0] cur_oe;
    int          cur_n;
    int          cur_start;
    logic [31:0] fr_bits  [$];
    logic [31:0] fr_oe    [$];
    int          fr_n     [$];
    int          fr_start [$];

    always @(negedge Clock) begin : mon
        logic sc;
        logic sd;
        sc = bus.SIO_C;
        sd = bus.SIO_D_OE ? bus.SIO_D_OUT : 1'b1;
        if (!NotReset) begin
            in_frame = 1'b0;
        end else if (prev_c && sc && (sd != prev_d)) begin
            if (!sd) begin
                in_frame  = 1'b1;
                cur_n     = 0;
                cur_bits  = '0;
                cur_oe    = '0;
                cur_start = cyc - t0;
            end else if (in_frame) begin
                fr_bits.push_back(cur_bits);
                fr_oe.push_back(cur_oe);
                fr_n.push_back(cur_n);
                fr_start.push_back(cur_start);
                in_frame = 1'b0;
            end
        end else if (!prev_c && sc && in_frame) begin
            cur_bits = {cur_bits[30:0], sd};
            cur_oe   = {cur_oe[30:0], bus.SIO_D_OE};
            cur_n++;
        end
        prev_c = sc;
        prev_d = sd;
    end

    task automatic clear_frames;
        fr_bits.delete();
        fr_oe.delete();
        fr_n.delete();
        fr_start.delete();
    endtask

    task automatic reset_and_release;
        @(negedge Clock);
        #2 NotReset = 1'b0;
        clear_frames();
        repeat (3) @(negedge Clock);
        #2 NotReset = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_done(input int bound, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                dc = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [20:0] got;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        NotReset = 1'b0;
        repeat (3) @(negedge Clock);
        got = {bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.RomAddr, Busy, Done, WriteCount};
        n_checks++;
        if (got !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got,
                     {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
        end
    endtask

    task automatic test_single_write;
        int          dc;
        logic [31:0] exp_bits;
        logic [31:0] exp_oe;
        exp_bits = {4'h0, 8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1, 1'b0};
        exp_oe   = {4'h0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        reset_and_release();
        @(negedge Clock);
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: got %b expected 1", Busy);
        end
        wait_done(1000, dc);
        n_checks++;
        if (dc !== 242) begin
            n_fail++;
            $display("FAIL single_done_cycle: got %0d expected 242", dc);
        end
        n_checks++;
        if ({WriteCount, bus.RomAddr, Busy} !== {8'd1, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_count_addr_busy: got wc=%0d addr=%0d busy=%b expected 1 1 0",
                     WriteCount, bus.RomAddr, Busy);
        end
        n_checks++;
        if (fr_n.size() !== 1) begin
            n_fail++;
            $display("FAIL single_frame_count: got %0d expected 1", fr_n.size());
        end else begin
            n_checks++;
            if ({fr_n[0], fr_start[0]} !== {32'd28, 32'd3}) begin
                n_fail++;
                $display("FAIL single_frame_shape: got bits=%0d start=%0d expected 28 3",
                         fr_n[0], fr_start[0]);
            end
            n_checks++;
            if (fr_bits[0] !== exp_bits) begin
                n_fail++;
                $display("FAIL single_frame_data: got %h expected %h", fr_bits[0], exp_bits);
            end
        end
    endtask

    task automatic test_dont_care;
        logic [31:0] exp_oe;
        exp_oe = {4'h0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
        n_checks++;
        if (fr_oe.size() !== 1) begin
            n_fail++;
            $display("FAIL dc_frame_count: got %0d expected 1", fr_oe.size());
        end else begin
            n_checks++;
            if (fr_oe[0] !== exp_oe) begin
                n_fail++;
                $display("FAIL dc_oe_mask: got %h expected %h", fr_oe[0], exp_oe);
            end
        end
    endtask

    task automatic test_delay;
        int          dc;
        logic [31:0] exp1;
        logic [31:0] exp_oe;
        exp1   = {4'h0, 8'h42, 1'b1, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0};
        exp_oe = {4'h0, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1100;
        reset_and_release();
        wait_done(2000, dc);
        n_checks++;
        if (dc !== 494) begin
            n_fail++;
            $display("FAIL delay_done_cycle: got %0d expected 494", dc);
        end
        n_checks++;
        if ({WriteCount, bus.RomAddr, Done} !== {8'd2, 8'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL delay_count_addr_done: got wc=%0d addr=%0d done=%b expected 2 3 1",
                     WriteCount, bus.RomAddr, Done);
        end
        n_checks++;
        if (fr_n.size() !== 2) begin
            n_fail++;
            $display("FAIL delay_frame_count: got %0d expected 2", fr_n.size());
        end else begin
            n_checks++;
            if ((fr_start[1] - fr_start[0]) !== 252) begin
                n_fail++;
                $display("FAIL delay_frame_spacing: got %0d expected 252",
                         fr_start[1] - fr_start[0]);
            end
            n_checks++;
            if ({fr_bits[1], fr_oe[1], fr_oe[0]} !== {exp1, exp_oe, exp_oe}) begin
                n_fail++;
                $display("FAIL delay_frame2: got data=%h oe=%h/%h expected %h %h",
                         fr_bits[1], fr_oe[0], fr_oe[1], exp1, exp_oe);
            end
        end
    endtask

    task automatic test_start_busy_and_restart;
        int          dc;
        logic [31:0] exp_bits;
        exp_bits = {4'h0, 8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1, 1'b0};
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        reset_and_release();
        repeat (20) @(negedge Clock);
        #2 Start = 1'b1;
        @(negedge Clock);
        #2 Start = 1'b0;
        wait_done(1000, dc);
        n_checks++;
        if ({dc, fr_n.size()} !== {32'd242, 32'd1}) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got done_cycle=%0d frames=%0d expected 242 1",
                     dc, fr_n.size());
        end

        clear_frames();
        repeat (3) @(negedge Clock);
        #2 Start = 1'b1;
        t0 = cyc;
        @(negedge Clock);
        n_checks++;
        if ({Done, bus.RomAddr, Busy, WriteCount} !== {1'b0, 8'd0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL restart_next_cycle: got done=%b addr=%0d busy=%b wc=%0d expected 0 0 1 0",
                     Done, bus.RomAddr, Busy, WriteCount);
        end
        #2 Start = 1'b0;
        wait_done(1000, dc);
        n_checks++;
        if (dc !== 243) begin
            n_fail++;
            $display("FAIL restart_done_cycle: got %0d expected 243", dc);
        end
        n_checks++;
        if (fr_n.size() !== 1) begin
            n_fail++;
            $display("FAIL restart_frame_count: got %0d expected 1", fr_n.size());
        end else begin
            n_checks++;
            if ({fr_bits[0], fr_start[0]} !== {exp_bits, 32'd4}) begin
                n_fail++;
                $display("FAIL restart_frame: got %h start=%0d expected %h 4",
                         fr_bits[0], fr_start[0], exp_bits);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int          dc;
        logic [31:0] exp0;
        logic [31:0] exp1;
        exp0 = {4'h0, 8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1, 1'b0};
        exp1 = {4'h0, 8'h42, 1'b1, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0};
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'h1100;
        reset_and_release();
        repeat (346) @(negedge Clock);
        n_checks++;
        if ({bus.RomAddr, Busy} !== {8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_pre: got addr=%0d busy=%b expected 1 1", bus.RomAddr, Busy);
        end
        #2 NotReset = 1'b0;
        #1;
        n_checks++;
        if ({bus.SIO_C, bus.SIO_D_OE, Busy, bus.RomAddr} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL midreset_immediate: got c=%b oe=%b busy=%b addr=%0d expected 1 0 0 0",
                     bus.SIO_C, bus.SIO_D_OE, Busy, bus.RomAddr);
        end
        clear_frames();
        repeat (2) @(negedge Clock);
        #2 NotReset = 1'b1;
        t0 = cyc;
        wait_done(2000, dc);
        n_checks++;
        if ({dc, 24'd0, WriteCount} !== {32'd483, 32'd2}) begin
            n_fail++;
            $display("FAIL midreset_rerun: got done_cycle=%0d wc=%0d expected 483 2", dc, WriteCount);
        end
        n_checks++;
        if (fr_n.size() !== 2) begin
            n_fail++;
            $display("FAIL midreset_frame_count: got %0d expected 2", fr_n.size());
        end else begin
            n_checks++;
            if ({fr_bits[0], fr_bits[1]} !== {exp0, exp1}) begin
                n_fail++;
                $display("FAIL midreset_frames: got %h %h expected %h %h",
                         fr_bits[0], fr_bits[1], exp0, exp1);
            end
        end
    endtask

    task automatic test_full_table;
        int          dc;
        int          bad;
        logic [7:0]  b;
        logic [31:0] exp;
        for (int i = 0; i < 256; i++) begin
            b      = 8'(i);
            rom[i] = {b, ~b};
        end
        reset_and_release();
        wait_done(70000, dc);
        n_checks++;
        if (dc !== 61696) begin
            n_fail++;
            $display("FAIL full_done_cycle: got %0d expected 61696", dc);
        end
        n_checks++;
        if ({WriteCount, bus.RomAddr, Done} !== {8'd255, 8'd255, 1'b1}) begin
            n_fail++;
            $display("FAIL full_count_addr_done: got wc=%0d addr=%0d done=%b expected 255 255 1",
                     WriteCount, bus.RomAddr, Done);
        end
        n_checks++;
        if (fr_n.size() !== 256) begin
            n_fail++;
            $display("FAIL full_frame_count: got %0d expected 256", fr_n.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                b   = 8'(i);
                exp = {4'h0, 8'h42, 1'b1, b, 1'b1, ~b, 1'b1, 1'b0};
                if ((fr_bits[i] !== exp) || (fr_n[i] !== 28)) bad++;
            end
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL full_frame_data: got %0d bad frames expected 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dont_care();
        test_delay();
        test_start_busy_and_restart();
        test_reset_midframe();
        test_full_table();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
